// File: rtl/sp_rx_pkg.sv
// sp_rx_pkg -- shared definitions for the serial-to-parallel receiver.
//   COMMA_DEFAULT      : idle/alignment symbol the TX serializer sends when idle
//   LOCK_COUNT_DEFAULT : consecutive aligned COMMAs needed to declare lock
//   state_t            : receiver alignment state
package sp_rx_pkg;

  localparam logic [7:0]  COMMA_DEFAULT      = 8'hBC;
  localparam int unsigned LOCK_COUNT_DEFAULT = 4;

  typedef enum logic [1:0] {
    SEARCH,
    LOCKING,
    ACTIVE
  } state_t;

endpackage

// File: rtl/sp_rx_deser.sv
// sp_rx_deser -- bit-level front end of the receiver.
// Shifts the serial stream MSB-first into an 8-bit register and counts bit
// slots so the FSM knows when a byte boundary occurs.
//   dclk      : serial bit clock (rising edge)
//   reset_L   : synchronous active-low reset
//   data_in   : serial bit stream
//   restart   : realign the bit counter; the next boundary falls 8 cycles later
//   sreg      : registered shift register (holds the last complete byte
//               for the cycle after a boundary)
//   byte_next : shift register value including the bit sampled this edge
//   boundary  : high in the cycle whose edge shifts in the 8th bit of a byte
module sp_rx_deser (
  input  logic       dclk,
  input  logic       reset_L,
  input  logic       data_in,
  input  logic       restart,
  output logic [7:0] sreg,
  output logic [7:0] byte_next,
  output logic       boundary
);

  logic [2:0] bit_cnt;

  assign byte_next = {sreg[6:0], data_in};
  assign boundary  = (bit_cnt == 3'd7);

  always_ff @(posedge dclk) begin
    if (!reset_L) begin
      sreg    <= '0;
      bit_cnt <= '0;
    end else begin
      sreg    <= byte_next;
      bit_cnt <= restart ? 3'd0 : bit_cnt + 3'd1;
    end
  end

endmodule

// File: rtl/serial_paralelo_rx.sv
// serial_paralelo_rx -- serial-to-parallel receiver with COMMA alignment.
// Hunts for COMMA at any bit phase, confirms LOCK_COUNT aligned COMMAs, then
// emits one byte per 8 dclk cycles, held stable for the whole byte period.
//   dclk      : serial bit clock, the only clock (rising edge)
//   reset_L   : synchronous active-low reset
//   data_in   : serial stream, MSB of each byte first
//   data_out  : recovered byte
//   valid_out : data_out holds a non-COMMA payload byte
//   active    : receiver locked
//   byte_tick : one-cycle pulse on each data_out load while locked
//   byte_cnt  : (only with SP_RX_BYTE_CNT_EN defined) saturating count of
//               payload bytes delivered since reset
module serial_paralelo_rx
  import sp_rx_pkg::*;
#(
  parameter logic [7:0]  COMMA      = COMMA_DEFAULT,
  parameter int unsigned LOCK_COUNT = LOCK_COUNT_DEFAULT
) (
  input  logic        dclk,
  input  logic        reset_L,
  input  logic        data_in,
  output logic [7:0]  data_out,
  output logic        valid_out,
  output logic        active,
  output logic        byte_tick
`ifdef SP_RX_BYTE_CNT_EN
  ,
  output logic [15:0] byte_cnt
`endif
);

  localparam int unsigned     CNT_W     = (LOCK_COUNT < 2) ? 1 : $clog2(LOCK_COUNT + 1);
  localparam logic [CNT_W-1:0] LOCK_MAX  = CNT_W'(LOCK_COUNT);
  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_COUNT - 1);

  state_t           state;
  logic [CNT_W-1:0] bc_cnt;
  logic             load_pend;
  logic [7:0]       sreg;
  logic [7:0]       byte_next;
  logic             boundary;
  logic             is_comma;
  logic             restart;

  assign is_comma = (byte_next == COMMA);
  // A COMMA seen while hunting defines the byte phase from here on.
  assign restart  = (state == SEARCH) && is_comma;

  sp_rx_deser u_deser (
    .dclk      (dclk),
    .reset_L   (reset_L),
    .data_in   (data_in),
    .restart   (restart),
    .sreg      (sreg),
    .byte_next (byte_next),
    .boundary  (boundary)
  );

  always_ff @(posedge dclk) begin
    if (!reset_L) begin
      state     <= SEARCH;
      bc_cnt    <= '0;
      load_pend <= 1'b0;
      data_out  <= '0;
      valid_out <= 1'b0;
      active    <= 1'b0;
      byte_tick <= 1'b0;
`ifdef SP_RX_BYTE_CNT_EN
      byte_cnt  <= '0;
`endif
    end else begin
      byte_tick <= 1'b0;
      load_pend <= 1'b0;

      // Output is loaded one edge after the boundary, from the registered
      // shift register, which still holds the completed byte in that cycle.
      if (load_pend) begin
        data_out  <= sreg;
        valid_out <= (sreg != COMMA);
        byte_tick <= 1'b1;
`ifdef SP_RX_BYTE_CNT_EN
        if ((sreg != COMMA) && (byte_cnt != 16'hFFFF)) begin
          byte_cnt <= byte_cnt + 16'd1;
        end
`endif
      end

      unique case (state)
        SEARCH: begin
          if (is_comma) begin
            state  <= LOCKING;
            bc_cnt <= CNT_W'(1);
          end
        end
        LOCKING: begin
          if (boundary) begin
            if (is_comma) begin
              if (bc_cnt != LOCK_MAX) begin
                bc_cnt <= bc_cnt + CNT_W'(1);
              end
              if (bc_cnt >= LOCK_LAST) begin
                state  <= ACTIVE;
                active <= 1'b1;
              end
            end else begin
              state  <= SEARCH;
              bc_cnt <= '0;
            end
          end
        end
        ACTIVE: begin
          if (boundary) begin
            load_pend <= 1'b1;
          end
        end
        default: begin
          state  <= SEARCH;
          active <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_paralelo_rx.sv
module tb_serial_paralelo_rx;

  localparam logic [7:0] COMMA = 8'hBC;

  logic       dclk;
  logic       reset_L;
  logic       data_in;
  logic [7:0] data_out;
  logic       valid_out;
  logic       active;
  logic       byte_tick;
`ifdef SP_RX_BYTE_CNT_EN
  logic [15:0] byte_cnt;
`endif

  serial_paralelo_rx #(
    .COMMA      (8'hBC),
    .LOCK_COUNT (4)
  ) dut (
    .dclk      (dclk),
    .reset_L   (reset_L),
    .data_in   (data_in),
    .data_out  (data_out),
    .valid_out (valid_out),
    .active    (active),
    .byte_tick (byte_tick)
`ifdef SP_RX_BYTE_CNT_EN
    ,
    .byte_cnt  (byte_cnt)
`endif
  );

  initial dclk = 1'b0;
  always #5 dclk = ~dclk;

  int unsigned cyc = 0;
  always @(posedge dclk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  typedef struct {
    logic [7:0]  data;
    logic        valid;
    int unsigned due;
  } exp_t;

  exp_t sb[$];

  // Monitor: every byte_tick must match the head of the scoreboard at the
  // predicted cycle; between ticks the locked outputs must not move.
  logic [7:0] held_data;
  logic       held_valid;
  bit         held_ok = 0;

  always @(negedge dclk) begin
    if (byte_tick === 1'b1) begin
      if (sb.size() == 0) begin
        check("spurious_tick", byte_tick, 1'b0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("tick_cycle", cyc, e.due);
        check("data_out", data_out, e.data);
        check("valid_out", valid_out, e.valid);
        held_data  = e.data;
        held_valid = e.valid;
        held_ok    = 1;
      end
    end else begin
      if (sb.size() != 0 && sb[0].due < cyc) begin
        check("tick_missing", byte_tick, 1'b1);
        void'(sb.pop_front());
      end
      if (active !== 1'b1) begin
        held_ok = 0;
      end else if (held_ok) begin
        check("hold_data", data_out, held_data);
        check("hold_valid", valid_out, held_valid);
      end
    end
  end

  task automatic send_bit(input logic b);
    data_in = b;
    @(negedge dclk);
  endtask

  // Drive one byte MSB first; when out_exp is set the byte is expected on
  // data_out two edges after its last bit is driven (sampled, then loaded).
  task automatic send_byte(input logic [7:0] b, input bit out_exp);
    for (int unsigned k = 0; k < 8; k++) begin
      data_in = b[7-k];
      if (k == 7 && out_exp) begin
        exp_t e;
        e.data  = b;
        e.valid = (b != COMMA);
        e.due   = cyc + 2;
        sb.push_back(e);
      end
      @(negedge dclk);
    end
  endtask

  task automatic drain();
    for (int unsigned k = 0; k < 5 && sb.size() != 0; k++) @(negedge dclk);
    check("drain_empty", sb.size(), 0);
    sb.delete();
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_data_out"}, data_out, 8'h00);
    check({tag, "_valid_out"}, valid_out, 1'b0);
    check({tag, "_active"}, active, 1'b0);
    check({tag, "_byte_tick"}, byte_tick, 1'b0);
  endtask

  task automatic do_reset();
    reset_L = 1'b0;
    data_in = 1'b0;
    repeat (3) @(negedge dclk);
    check_outputs_zero("reset");
    reset_L = 1'b1;
  endtask

  // Lock sequence: 4 COMMAs, active must rise exactly with the 4th one.
  task automatic lock4(input string tag);
    for (int unsigned k = 0; k < 4; k++) begin
      send_byte(COMMA, 1'b0);
      check({tag, "_active"}, active, (k == 3) ? 1'b1 : 1'b0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_L = 1'b0;
    data_in = 1'b0;
    @(negedge dclk);
    do_reset();

    // Lock test, then a mid-byte reset while ACTIVE and a fresh relock.
    lock4("lock");
    send_byte(8'hFF, 1'b1);
    send_byte(8'h81, 1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    reset_L = 1'b0;
    data_in = 1'b1;
    @(negedge dclk);
    check_outputs_zero("midreset");
    reset_L = 1'b1;
    lock4("relock");
    send_byte(8'h3C, 1'b1);
    send_byte(COMMA, 1'b1);
    drain();

    // Arbitrary phase: 3 garbage bits ahead of the COMMAs.
    do_reset();
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    lock4("phase");
    send_byte(COMMA, 1'b1);
    send_byte(8'hFF, 1'b1);
    send_byte(8'hDD, 1'b1);
    send_byte(8'hEE, 1'b1);
    send_byte(8'hCC, 1'b1);
    send_byte(COMMA, 1'b1);
    drain();
`ifdef SP_RX_BYTE_CNT_EN
    check("byte_cnt", byte_cnt, 16'd4);
`endif

    // Broken lock: a non-COMMA after two COMMAs discards the progress.
    do_reset();
    send_byte(COMMA, 1'b0);
    send_byte(COMMA, 1'b0);
    send_byte(8'h12, 1'b0);
    check("broken_active", active, 1'b0);
    lock4("broken");
    send_byte(8'h5A, 1'b1);

    // Idle gap while locked.
    send_byte(8'hDD, 1'b1);
    for (int unsigned k = 0; k < 3; k++) send_byte(COMMA, 1'b1);
    check("gap_active", active, 1'b1);
    send_byte(8'hEE, 1'b1);
    send_byte(COMMA, 1'b1);
    drain();
    check("end_active", active, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/serial_paralelo_rx.md
SERIAL_PARALELO_RX -- requirements
Module: serial_paralelo_rx

Interface
REQ-001 Parameter COMMA, default 8'hBC, idle/alignment symbol sent by the TX serializer when its valid is low.
REQ-002 Parameter LOCK_COUNT, default 4, number of consecutive aligned COMMA bytes required to enter ACTIVE.
REQ-003 Port dclk  input  1  serial bit clock; the only clock, rising-edge.
REQ-004 Port reset_L  input  1  reset, synchronous to dclk, active-low.
REQ-005 Port data_in  input  1  serial bit stream, MSB of each byte first.
REQ-006 Port data_out  output  8  recovered byte.
REQ-007 Port valid_out  output  1  data_out holds a non-COMMA payload byte.
REQ-008 Port active  output  1  receiver locked (state ACTIVE).
REQ-009 Port byte_tick  output  1  one-dclk pulse marking each new byte boundary while aligned.

Function
REQ-010 The block SHALL shift data_in into an 8-bit shift register every dclk edge: sreg <= {sreg[6:0], data_in}.
REQ-011 The FSM SHALL have exactly three states: SEARCH, LOCKING, ACTIVE.
REQ-012 In SEARCH, the updated sreg SHALL be compared with COMMA every cycle; on a match the block SHALL go to LOCKING, set bc_cnt to 1, and restart the 3-bit bit counter so the next boundary falls 8 cycles later.
REQ-013 In LOCKING and ACTIVE, the bit counter SHALL wrap modulo 8, and a byte boundary is the cycle in which the 8th bit is shifted in.
REQ-014 In LOCKING at a boundary, a COMMA byte SHALL increment bc_cnt; when bc_cnt reaches LOCK_COUNT, the block SHALL enter ACTIVE on that edge.
REQ-015 In LOCKING at a boundary, a non-COMMA byte SHALL return the FSM to SEARCH with bc_cnt cleared.
REQ-016 ACTIVE SHALL persist until reset; there is no loss-of-lock exit.
REQ-017 In ACTIVE at each boundary, data_out SHALL load the assembled byte on the next dclk edge, one cycle after its last bit was sampled.
REQ-018 On each such load, valid_out SHALL be set to 1 for a non-COMMA byte and to 0 for a COMMA byte.
REQ-019 data_out and valid_out SHALL be held stable for the full 8-cycle byte period, so a dclk/8 consumer samples each byte exactly once.
REQ-020 byte_tick SHALL pulse for one cycle coincident with each data_out load in ACTIVE, and SHALL stay 0 otherwise.
REQ-021 The boundary byte that completes the LOCK_COUNT-th COMMA SHALL NOT assert valid_out.
REQ-022 The first payload byte SHALL be the first byte boundary after entering ACTIVE.
REQ-023 active SHALL equal (state == ACTIVE), registered.
REQ-024 bc_cnt SHALL be wide enough for LOCK_COUNT and SHALL saturate rather than wrap.

Reset
REQ-025 When reset_L=0 at a dclk edge, the block SHALL clear sreg, the bit counter and bc_cnt, and SHALL set state to SEARCH.
REQ-026 Reset SHALL also set data_out=8'h00, valid_out=0, active=0 and byte_tick=0.
REQ-027 Reset asserted mid-byte or in ACTIVE SHALL take effect on that edge; the partial byte is discarded and nothing is output.
REQ-028 After reset release, search SHALL resume from the first sampled bit.

Configuration
REQ-029 With macro SP_RX_BYTE_CNT_EN defined, the block SHALL add output byte_cnt[15:0].
REQ-030 byte_cnt SHALL count valid_out loads, saturate at 16'hFFFF, and reset to 0.
REQ-031 Without SP_RX_BYTE_CNT_EN, the port and counter SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-032 Package sp_rx_pkg SHALL hold the COMMA default, the LOCK_COUNT default and the state enum {SEARCH, LOCKING, ACTIVE}.
REQ-033 One sub-module, sp_rx_deser, SHALL implement the shift register, bit counter and boundary strobe.
REQ-034 The FSM and output registers SHALL reside in serial_paralelo_rx.

Verification
REQ-035 Lock test: reset, then 4 x 8'hBC MSB-first, then 8'hFF.
- active SHALL rise at the 4th boundary.
- data_out=8'hFF with valid_out=1 SHALL appear 1 cycle after its last bit and hold 8 cycles.
REQ-036 Arbitrary phase: 3 garbage bits, then 5 x BC, then FF, DD, EE, CC, then BC.
- Lock SHALL be reached.
- FF, DD, EE, CC SHALL be output with valid_out=1, each held 8 cycles.
- The trailing BC SHALL drive valid_out=0.
REQ-037 Broken lock: BC, BC, 8'h12, then 4 x BC.
- The FSM SHALL return to SEARCH at 8'h12.
- active SHALL rise only after the later 4 BCs.
REQ-038 Reset mid-stream: in ACTIVE, drop reset_L for 1 cycle mid-byte.
- All outputs SHALL be 0 on the next edge.
- Relock SHALL require 4 fresh BCs.
REQ-039 Idle gap in ACTIVE: payload 8'hDD, then 3 x BC, then 8'hEE.
- valid_out SHALL be 0 for the 3 BC periods.
- active SHALL remain 1.
- 8'hEE SHALL be output valid.
REQ-040 With SP_RX_BYTE_CNT_EN defined, after the REQ-036 stream byte_cnt SHALL equal 4.
